// File: rtl/ibex_if_pair_fifo.sv
// ibex_if_pair_fifo: instruction-word FIFO that presents the two oldest entries to the ID stage.
// Defining IBEX_IF_FIFO_BYPASS_EN forwards a word arriving at an empty FIFO straight to slot 0.
module ibex_if_pair_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 34
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_rdata_i,
  output logic             in_ready_o,
  output logic [1:0]       out_valid_o,
  output logic [WIDTH-1:0] out_rdata_o [2],
  input  logic [1:0]       out_pop_i,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rptr, wptr;
  logic [CW-1:0]    cnt;
  logic [1:0]       rvld, n;
  logic             push, byp_take;
  assign count_o    = cnt;
  assign in_ready_o = cnt < CW'(DEPTH);
  assign rvld       = {cnt >= CW'(2), cnt != '0};
  // Slot 1 only counts when slot 0 is also taken; a lone slot-1 pop is ignored.
  assign n = (out_pop_i[0] & rvld[0]) ? ((out_pop_i[1] & rvld[1]) ? 2'd2 : 2'd1) : 2'd0;
  assign out_rdata_o[1] = mem[rptr + AW'(1)];
`ifdef IBEX_IF_FIFO_BYPASS_EN
  logic byp;
  assign byp            = (cnt == '0) & in_valid_i & ~flush_i;
  assign byp_take       = byp & out_pop_i[0];
  assign out_valid_o    = {rvld[1], rvld[0] | byp};
  assign out_rdata_o[0] = byp ? in_rdata_i : mem[rptr];
`else
  assign byp_take       = 1'b0;
  assign out_valid_o    = rvld;
  assign out_rdata_o[0] = mem[rptr];
`endif
  assign push = in_valid_i & in_ready_o & ~flush_i & ~byp_take;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush_i) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= in_rdata_i;
        wptr      <= wptr + AW'(1);
      end
      rptr <= rptr + AW'(n);
      cnt  <= cnt + CW'(push) - CW'(n);
    end
  end
endmodule
